// File: rtl/rr_pop_arbiter.sv
// rr_pop_arbiter: round-robin pop arbiter over NUM_CH input FIFOs with registered head-word output.
// Defining RR_BURST_EN lets a channel keep the grant for up to BURST consecutive pops.
module rr_pop_arbiter #(
    parameter int NUM_CH = 4,
    parameter int ID_W   = 2,
    parameter int DATA_W = 5,
    parameter int BURST  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] request,
    input  logic [NUM_CH-1:0]        empty,
    input  logic                     almost_full,
    output logic [NUM_CH-1:0]        pop,
    output logic [ID_W-1:0]          pop_id,
    output logic [DATA_W-1:0]        data_out,
    output logic                     valid
);
    typedef enum logic [1:0] {IDLE, SERVE, HOLD} state_t;
    state_t state, state_nxt;
    logic [ID_W-1:0] ptr, ptr_nxt, cand, cand_inc, idx;
    logic found, grant;
    // Explicit wrap keeps the rotation correct for non-power-of-two channel counts.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        return ID_W'(s >= NUM_CH ? s - NUM_CH : s);
    endfunction
    always_comb begin
        cand = ptr;
        idx = ptr;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = wrap_add(ptr, i);
            if (!empty[idx]) cand = idx;
        end
        found = |(~empty);
        grant = reset && !almost_full && found;
        pop = grant ? NUM_CH'(1) << cand : '0;
        cand_inc = wrap_add(cand, 1);
        state_nxt = grant ? SERVE : almost_full ? HOLD : IDLE;
    end
`ifdef RR_BURST_EN
    logic [3:0] burst_cnt, cnt_base, cnt_nxt;
    logic keep;
    // A skipped pointer channel means a fresh burst starts on the candidate.
    always_comb begin
        cnt_base = (cand == ptr) ? burst_cnt : 4'd0;
        keep = int'(cnt_base) < BURST - 1;
        ptr_nxt = !grant ? ptr : keep ? cand : cand_inc;
        cnt_nxt = !grant ? burst_cnt : keep ? cnt_base + 4'd1 : 4'd0;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) burst_cnt <= '0;
        else burst_cnt <= cnt_nxt;
    end
`else
    always_comb ptr_nxt = grant ? cand_inc : ptr;
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= '0;
            valid    <= 1'b0;
            pop_id   <= '0;
            data_out <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            valid <= grant;
            if (grant) begin
                pop_id   <= cand;
                data_out <= request[cand*DATA_W +: DATA_W];
            end
        end
    end
endmodule

// File: tb/tb_rr_pop_arbiter.sv
// tb_rr_pop_arbiter: scoreboard bench for rr_pop_arbiter; burst scenarios run when RR_BURST_EN is defined.
module tb_rr_pop_arbiter;
    logic        clk, reset, almost_full, valid;
    logic [19:0] request;
    logic [3:0]  empty, pop, exp_pop;
    logic [1:0]  pop_id;
    logic [4:0]  data_out;
    typedef struct {logic [1:0] id; logic [4:0] d;} exp_t;
    exp_t q[$];
    exp_t e, last;
    int tests, fails;

    rr_pop_arbiter #(.NUM_CH(4), .ID_W(2), .DATA_W(5), .BURST(3)) dut (
        .clk(clk), .reset(reset), .request(request), .empty(empty),
        .almost_full(almost_full), .pop(pop), .pop_id(pop_id),
        .data_out(data_out), .valid(valid)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic test_reset;
        reset = 0;
        repeat (3) @(negedge clk);
        reset = 1;
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (pop !== 4'b0 || valid !== 1'b0 || pop_id !== 2'd0 || data_out !== 5'd0) begin
                fails++;
                $display("FAIL reset cyc%0d pop=%b valid=%b id=%0d data=%0d, required all zero", i, pop, valid, pop_id, data_out);
            end
            @(negedge clk);
        end
    endtask

`ifndef RR_BURST_EN
    task automatic test_rotation;
        int ids[6] = '{0, 1, 2, 3, 0, -1};
        logic [3:0] es[6] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF};
        for (int i = 0; i < 6; i++) begin
            empty = es[i]; almost_full = 0; #1;
            exp_pop = ids[i] < 0 ? 4'b0 : 4'b1 << ids[i];
            tests++;
            if (pop !== exp_pop) begin fails++; $display("FAIL rotation_pop cyc%0d got %b want %b", i, pop, exp_pop); end
            if (ids[i] >= 0) q.push_back('{2'(ids[i]), request[ids[i]*5 +: 5]});
            @(negedge clk);
            tests++;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (valid !== 1'b1 || pop_id !== e.id || data_out !== e.d) begin fails++; $display("FAIL rotation_out cyc%0d got v=%b id=%0d d=%0d want v=1 id=%0d d=%0d", i, valid, pop_id, data_out, e.id, e.d); end
                last = e;
            end else if (valid !== 1'b0 || pop_id !== last.id || data_out !== last.d) begin fails++; $display("FAIL rotation_idle cyc%0d got v=%b id=%0d d=%0d want v=0 id=%0d d=%0d", i, valid, pop_id, data_out, last.id, last.d); end
        end
    endtask

    task automatic test_single_and_wrap;
        int ids[8] = '{2, 2, 2, 2, 0, 2, 0, 2};
        logic [3:0] es[8] = '{4'hB, 4'hB, 4'hB, 4'hB, 4'hA, 4'hA, 4'hA, 4'hA};
        for (int i = 0; i < 8; i++) begin
            empty = es[i]; almost_full = 0; #1;
            exp_pop = 4'b1 << ids[i];
            tests++;
            if (pop !== exp_pop) begin fails++; $display("FAIL single_pop cyc%0d got %b want %b", i, pop, exp_pop); end
            q.push_back('{2'(ids[i]), request[ids[i]*5 +: 5]});
            @(negedge clk);
            tests++;
            e = q.pop_front();
            if (valid !== 1'b1 || pop_id !== e.id || data_out !== e.d) begin fails++; $display("FAIL single_out cyc%0d got v=%b id=%0d d=%0d want v=1 id=%0d d=%0d", i, valid, pop_id, data_out, e.id, e.d); end
            last = e;
        end
    endtask

    task automatic test_stall;
        int ids[6] = '{3, -1, -1, -1, 0, 1};
        logic afs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            empty = 4'h0; almost_full = afs[i]; #1;
            exp_pop = ids[i] < 0 ? 4'b0 : 4'b1 << ids[i];
            tests++;
            if (pop !== exp_pop) begin fails++; $display("FAIL stall_pop cyc%0d got %b want %b", i, pop, exp_pop); end
            if (ids[i] >= 0) q.push_back('{2'(ids[i]), request[ids[i]*5 +: 5]});
            @(negedge clk);
            tests++;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (valid !== 1'b1 || pop_id !== e.id || data_out !== e.d) begin fails++; $display("FAIL stall_out cyc%0d got v=%b id=%0d d=%0d want v=1 id=%0d d=%0d", i, valid, pop_id, data_out, e.id, e.d); end
                last = e;
            end else if (valid !== 1'b0 || pop_id !== last.id || data_out !== last.d) begin fails++; $display("FAIL stall_hold cyc%0d got v=%b id=%0d d=%0d want v=0 id=%0d d=%0d", i, valid, pop_id, data_out, last.id, last.d); end
        end
        almost_full = 0;
    endtask
`else
    task automatic test_burst;
        int ids[10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3};
        reset = 0; @(negedge clk); reset = 1; q.delete(); last = '{2'd0, 5'd0};
        for (int i = 0; i < 10; i++) begin
            empty = 4'h0; almost_full = 0; #1;
            exp_pop = 4'b1 << ids[i];
            tests++;
            if (pop !== exp_pop) begin fails++; $display("FAIL burst_pop cyc%0d got %b want %b", i, pop, exp_pop); end
            q.push_back('{2'(ids[i]), request[ids[i]*5 +: 5]});
            @(negedge clk);
            tests++;
            e = q.pop_front();
            if (valid !== 1'b1 || pop_id !== e.id || data_out !== e.d) begin fails++; $display("FAIL burst_out cyc%0d got v=%b id=%0d d=%0d want v=1 id=%0d d=%0d", i, valid, pop_id, data_out, e.id, e.d); end
            last = e;
        end
    endtask

    task automatic test_burst_empty_hold;
        int ids[8] = '{0, 0, 0, 1, 2, -1, 2, 2};
        logic [3:0] es[8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2};
        logic afs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        reset = 0; @(negedge clk); reset = 1; q.delete(); last = '{2'd0, 5'd0};
        for (int i = 0; i < 8; i++) begin
            empty = es[i]; almost_full = afs[i]; #1;
            exp_pop = ids[i] < 0 ? 4'b0 : 4'b1 << ids[i];
            tests++;
            if (pop !== exp_pop) begin fails++; $display("FAIL burst2_pop cyc%0d got %b want %b", i, pop, exp_pop); end
            if (ids[i] >= 0) q.push_back('{2'(ids[i]), request[ids[i]*5 +: 5]});
            @(negedge clk);
            tests++;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (valid !== 1'b1 || pop_id !== e.id || data_out !== e.d) begin fails++; $display("FAIL burst2_out cyc%0d got v=%b id=%0d d=%0d want v=1 id=%0d d=%0d", i, valid, pop_id, data_out, e.id, e.d); end
                last = e;
            end else if (valid !== 1'b0 || pop_id !== last.id || data_out !== last.d) begin fails++; $display("FAIL burst2_hold cyc%0d got v=%b id=%0d d=%0d want v=0 id=%0d d=%0d", i, valid, pop_id, data_out, last.id, last.d); end
        end
        almost_full = 0;
    endtask
`endif

    task automatic test_reset_mid;
`ifdef RR_BURST_EN
        int ids[4] = '{0, 0, 0, 1};
`else
        int ids[4] = '{0, 1, 2, 3};
`endif
        reset = 0; @(negedge clk); reset = 1; q.delete(); last = '{2'd0, 5'd0};
        for (int i = 0; i < 4; i++) begin
            empty = 4'h0; almost_full = 0; #1;
            exp_pop = 4'b1 << ids[i];
            tests++;
            if (pop !== exp_pop) begin fails++; $display("FAIL midrst_pop cyc%0d got %b want %b", i, pop, exp_pop); end
            q.push_back('{2'(ids[i]), request[ids[i]*5 +: 5]});
            @(negedge clk);
            tests++;
            e = q.pop_front();
            if (valid !== 1'b1 || pop_id !== e.id || data_out !== e.d) begin fails++; $display("FAIL midrst_out cyc%0d got v=%b id=%0d d=%0d want v=1 id=%0d d=%0d", i, valid, pop_id, data_out, e.id, e.d); end
        end
        #2 reset = 0; #1;
        tests++;
        if (pop !== 4'b0 || valid !== 1'b0 || pop_id !== 2'd0 || data_out !== 5'd0) begin
            fails++;
            $display("FAIL midrst_async pop=%b valid=%b id=%0d data=%0d, required all zero", pop, valid, pop_id, data_out);
        end
        @(negedge clk); @(negedge clk);
        reset = 1; #1;
        tests++;
        if (pop !== 4'b0001) begin fails++; $display("FAIL midrst_first_pop got %b want 0001", pop); end
        @(negedge clk);
        tests++;
        if (valid !== 1'b1 || pop_id !== 2'd0 || data_out !== 5'd1) begin fails++; $display("FAIL midrst_first_out got v=%b id=%0d d=%0d want v=1 id=0 d=1", valid, pop_id, data_out); end
    endtask

    initial begin
        tests = 0; fails = 0;
        reset = 0; empty = 4'hF; almost_full = 0;
        request = {5'd4, 5'd3, 5'd2, 5'd1};
        last = '{2'd0, 5'd0};
        test_reset();
`ifndef RR_BURST_EN
        test_rotation();
        test_single_and_wrap();
        test_stall();
`else
        test_burst();
        test_burst_empty_hold();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
